// File: rtl/ml_axi_pkg.sv
// Shared AXI constants, reader state encoding and the burst-sizing helper
// for the model-reader slice.
package ml_axi_pkg;

    localparam int          WORD_W        = 16;
    localparam int          BEAT_SHIFT    = 5;      // 32-byte beats
    localparam int          BEATS_W       = 20;
    localparam int          WORDS_W       = 24;
    localparam logic [2:0]  AXI_SIZE_32B  = 3'd5;
    localparam logic [1:0]  BURST_INCR    = 2'b01;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [3:0]  CACHE_NORMAL  = 4'b0011;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_AR    = 2'd1,
        RD_R     = 2'd2,
        RD_DRAIN = 2'd3
    } rd_state_e;

    // Beats in the next burst: bounded by what is left, the burst cap and
    // the distance to the next 4 KB page, which AXI bursts must not cross.
    function automatic logic [8:0] burst_beats(input logic [BEATS_W-1:0] beats_left,
                                               input logic [11:0]        page_off,
                                               input int                 max_len);
        logic [BEATS_W-1:0] n;
        logic [BEATS_W-1:0] to_page;
        to_page = BEATS_W'(128) - BEATS_W'(page_off[11:BEAT_SHIFT]);
        n = beats_left;
        if (n > BEATS_W'(max_len)) n = BEATS_W'(max_len);
        if (n > to_page)           n = to_page;
        return n[8:0];
    endfunction

endpackage

// File: rtl/ml_beat_unpacker.sv
// Holds one read beat and streams it out as 16-bit words, tracking how many
// words of the whole transfer remain so a partial last beat is cut short.
module ml_beat_unpacker
    import ml_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_i,
    input  logic [WORDS_W-1:0]    num_words_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  out_ready_i,
    output logic                  can_load_o,
    output logic                  last_hs_o,
    output logic [WORD_W-1:0]     out_data_o,
    output logic                  out_valid_o,
    output logic                  out_last_o
);

    localparam int WPB   = DATA_WIDTH / WORD_W;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORDS_W-1:0]    words_left_q, words_left_d;

    logic out_hs;
    logic final_word;
    logic hold_done;

    assign out_hs     = hold_valid_q & out_ready_i;
    assign final_word = (idx_q == IDX_W'(WPB - 1)) | (words_left_q == WORDS_W'(1));
    assign hold_done  = out_hs & final_word;

    // The FSM may refill in the same cycle the last word of the hold leaves,
    // which is what keeps the stream bubble-free.
    assign can_load_o  = ~hold_valid_q | hold_done;
    assign last_hs_o   = out_hs & (words_left_q == WORDS_W'(1));
    assign out_data_o  = hold_q[WORD_W*idx_q +: WORD_W];
    assign out_valid_o = hold_valid_q;
    assign out_last_o  = hold_valid_q & (words_left_q == WORDS_W'(1));

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        idx_d        = idx_q;
        words_left_d = words_left_q;
        if (out_hs) begin
            words_left_d = words_left_q - WORDS_W'(1);
            idx_d        = idx_q + IDX_W'(1);
        end
        if (hold_done) begin
            hold_valid_d = 1'b0;
        end
        if (load_i) begin
            hold_d       = load_data_i;
            hold_valid_d = 1'b1;
            idx_d        = '0;
        end
        if (init_i) begin
            words_left_d = num_words_i;
            hold_valid_d = 1'b0;
            idx_d        = '0;
        end
    end

    // NOTE: reset is synchronous (sampled on clk); the hold register is a single
    // flop vector, not a memory, so it is cleared too and out_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            idx_q        <= '0;
            words_left_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            idx_q        <= idx_d;
            words_left_q <= words_left_d;
        end
    end

endmodule

// File: rtl/sd_axi_model_reader.sv
// AXI4 read master: fetches model data from DDR in INCR bursts split at 4 KB
// pages and streams it out as 16-bit words with a last flag.
module sd_axi_model_reader
    import ml_axi_pkg::*;
#(
    parameter int              DATA_WIDTH = 256,
    parameter int              ADDR_WIDTH = 32,
    parameter int              ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID = 8'd41,
    parameter int              BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [WORDS_W-1:0]    num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arlock,
    output logic [3:0]            m_arcache,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int WPB_SHIFT = $clog2(DATA_WIDTH / WORD_W);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEATS_W-1:0]    beats_left_q, beats_left_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [8:0]            n_beats;
    logic [WORDS_W:0]      words_round;
    logic                  start_ok;
    logic                  can_load;
    logic                  load;
    logic                  last_hs;
    logic                  unused_bits;

    assign unused_bits = ^{m_rid, base_addr[BEAT_SHIFT-1:0]};

    assign n_beats     = burst_beats(beats_left_q, addr_q[11:0], BURST_LEN);
    assign words_round = {1'b0, num_words} + (WORDS_W + 1)'((DATA_WIDTH / WORD_W) - 1);
    assign start_ok    = (state_q == RD_IDLE) & start;
    assign m_rready    = (state_q == RD_R) & can_load;
    assign load        = m_rvalid & m_rready;

    assign m_arid    = AXI_ID;
    assign m_araddr  = addr_q;
    assign m_arlen   = (state_q == RD_AR) ? 8'(n_beats - 9'd1) : 8'd0;
    assign m_arsize  = AXI_SIZE_32B;
    assign m_arburst = BURST_INCR;
    assign m_arlock  = 1'b0;
    assign m_arcache = CACHE_NORMAL;
    assign m_arprot  = 3'd0;
    assign m_arvalid = (state_q == RD_AR);

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    ml_beat_unpacker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_unpacker (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_i      (start_ok),
        .num_words_i (num_words),
        .load_i      (load),
        .load_data_i (m_rdata),
        .out_ready_i (out_ready),
        .can_load_o  (can_load),
        .last_hs_o   (last_hs),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_last_o  (out_last)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        unique case (state_q)
            RD_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (num_words != '0) begin
                        addr_d       = {base_addr[ADDR_WIDTH-1:BEAT_SHIFT], BEAT_SHIFT'(0)};
                        beats_left_d = BEATS_W'(words_round >> WPB_SHIFT);
                        busy_d       = 1'b1;
                        state_d      = RD_AR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD_AR: begin
                if (m_arready) state_d = RD_R;
            end
            RD_R: begin
                // Counters advance once per burst; n_beats is stable until then.
                if (load && m_rlast) begin
                    beats_left_d = beats_left_q - BEATS_W'(n_beats);
                    addr_d       = addr_q + ADDR_WIDTH'({n_beats, BEAT_SHIFT'(0)});
                    state_d      = (beats_left_q == BEATS_W'(n_beats)) ? RD_DRAIN : RD_AR;
                end
            end
            RD_DRAIN: begin
                if (last_hs) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
        if (load && (m_rresp != RESP_OKAY)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RD_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule
